// File: rtl/wb_pkg.sv
// Write-back stage shared definitions: control bundle bit map and field codes.
package wb_pkg;
  localparam int WB_RF_EN    = 9;
  localparam int WB_MEM2REG  = 8;
  localparam int WB_SIZE_HI  = 7;
  localparam int WB_SIZE_LO  = 6;
  localparam int WB_UNS      = 5;
  localparam int WB_SRC_HI   = 4;
  localparam int WB_SRC_LO   = 3;
  localparam int WB_HI_EN    = 2;
  localparam int WB_LO_EN    = 1;
  localparam int WB_HILO_SRC = 0;

  typedef enum logic [1:0] {
    SZ_WORD  = 2'b00,
    SZ_BYTE  = 2'b01,
    SZ_HALF  = 2'b10,
    SZ_WORD2 = 2'b11
  } ld_size_e;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_HI   = 2'b01,
    SRC_LO   = 2'b10,
    SRC_ALU2 = 2'b11
  } wb_src_e;
endpackage

// File: rtl/wb_if.sv
// MEM/WB -> write-back bus: registered control plus the operands the stage consumes.
interface wb_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 22
);
  logic [CTRL_W-1:0] control_signals;
  logic              rf_enable;
  logic              hi_enable;
  logic              lo_enable;
  logic              stall;
  logic [4:0]        dest_reg;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] mul_hi;
  logic [DATA_W-1:0] mul_lo;

  modport master (output control_signals, rf_enable, hi_enable, lo_enable, stall,
                  dest_reg, alu_result, mem_data, mul_hi, mul_lo);
  modport slave  (input  control_signals, rf_enable, hi_enable, lo_enable, stall,
                  dest_reg, alu_result, mem_data, mul_hi, mul_lo);
endinterface

// File: rtl/wb_stage_load_align.sv
// Combinational load aligner: picks the addressed byte/half and sign/zero extends.
module load_align
  import wb_pkg::*;
(
  input  logic [31:0] mem_data,
  input  logic [1:0]  offset,
  input  ld_size_e    size,
  input  logic        is_unsigned,
  output logic [31:0] value
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = mem_data[7:0];
    case (offset)
      2'd0: byte_v = mem_data[7:0];
      2'd1: byte_v = mem_data[15:8];
      2'd2: byte_v = mem_data[23:16];
      2'd3: byte_v = mem_data[31:24];
      default: byte_v = mem_data[7:0];
    endcase
    half_v = offset[1] ? mem_data[31:16] : mem_data[15:0];

    value = mem_data;
    case (size)
      SZ_BYTE: value = {{24{~is_unsigned & byte_v[7]}}, byte_v};
      SZ_HALF: value = {{16{~is_unsigned & half_v[15]}}, half_v};
      default: value = mem_data;
    endcase
  end
endmodule

// File: rtl/wb_stage.sv
// Write-back stage: data select/align, HI/LO ownership, RF write port,
// last-write forwarding record and retired-write counter.
module wb_stage
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 22,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  wb_if.slave               wb,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              fwd_valid,
  output logic [4:0]        fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retired_count
);
  logic [CTRL_W-1:0] ctrl;
  logic              mem2reg, uns, hilo_src;
  ld_size_e          size;
  wb_src_e           src;
  logic [DATA_W-1:0] load_v, sel_data, hi_in, lo_in;
  logic              gpr_commit, hi_commit, lo_commit, retire;

  assign ctrl     = wb.control_signals;
  assign mem2reg  = ctrl[WB_MEM2REG];
  assign size     = ld_size_e'(ctrl[WB_SIZE_HI:WB_SIZE_LO]);
  assign uns      = ctrl[WB_UNS];
  assign src      = wb_src_e'(ctrl[WB_SRC_HI:WB_SRC_LO]);
  assign hilo_src = ctrl[WB_HILO_SRC];

  // Enable copies in the bundle are redundant with the discrete enable ports.
  logic unused_ctrl;
  assign unused_ctrl = ^{ctrl[CTRL_W-1:10], ctrl[WB_RF_EN], ctrl[WB_HI_EN], ctrl[WB_LO_EN]};

  load_align u_align (
    .mem_data    (wb.mem_data),
    .offset      (wb.alu_result[1:0]),
    .size        (size),
    .is_unsigned (uns),
    .value       (load_v)
  );

  // HI/LO sources read the registered value, so a same-cycle MTHI is not seen.
  always_comb begin
    sel_data = wb.alu_result;
    if (mem2reg) sel_data = load_v;
    else begin
      case (src)
        SRC_HI:  sel_data = hi_out;
        SRC_LO:  sel_data = lo_out;
        default: sel_data = wb.alu_result;
      endcase
    end
  end

  assign hi_in      = hilo_src ? wb.alu_result : wb.mul_hi;
  assign lo_in      = hilo_src ? wb.alu_result : wb.mul_lo;
  assign gpr_commit = wb.rf_enable & (wb.dest_reg != 5'd0) & ~wb.stall;
  assign hi_commit  = wb.hi_enable & ~wb.stall;
  assign lo_commit  = wb.lo_enable & ~wb.stall;
  // One per retired instruction; a discarded $0 write still retires.
  assign retire     = ~wb.stall & (wb.rf_enable | wb.hi_enable | wb.lo_enable);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we         <= 1'b0;
      rf_waddr      <= '0;
      rf_wdata      <= '0;
      hi_out        <= '0;
      lo_out        <= '0;
      fwd_valid     <= 1'b0;
      fwd_reg       <= '0;
      fwd_data      <= '0;
      retired_count <= '0;
    end else begin
      rf_we <= gpr_commit;
      if (!wb.stall) begin
        rf_waddr <= wb.dest_reg;
        rf_wdata <= sel_data;
      end
      if (hi_commit) hi_out <= hi_in;
      if (lo_commit) lo_out <= lo_in;
      if (gpr_commit) begin
        fwd_valid <= 1'b1;
        fwd_reg   <= wb.dest_reg;
        fwd_data  <= sel_data;
      end
      if (retire) retired_count <= retired_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage; a 4-bit-counter instance covers counter wrap.
module tb_wb_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  wb_if #(.DATA_W(32), .CTRL_W(22)) bus ();

  logic        rf_we, fwd_valid;
  logic [4:0]  rf_waddr, fwd_reg;
  logic [31:0] rf_wdata, hi_out, lo_out, fwd_data, retired_count;

  logic        rf_we4, fwd_valid4;
  logic [4:0]  rf_waddr4, fwd_reg4;
  logic [31:0] rf_wdata4, hi_out4, lo_out4, fwd_data4;
  logic [3:0]  retired_count4;

  wb_stage dut (
    .clk(clk), .reset(reset), .wb(bus),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .hi_out(hi_out), .lo_out(lo_out),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .retired_count(retired_count)
  );

  wb_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .wb(bus),
    .rf_we(rf_we4), .rf_waddr(rf_waddr4), .rf_wdata(rf_wdata4),
    .hi_out(hi_out4), .lo_out(lo_out4),
    .fwd_valid(fwd_valid4), .fwd_reg(fwd_reg4), .fwd_data(fwd_data4),
    .retired_count(retired_count4)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // {ignored junk, rf_en copy=0, mem2reg, size, uns, wb_src, hi/lo copies=0, hilo_src}
  function automatic logic [21:0] mk(input logic m2r, input logic [1:0] sz, input logic uns,
                                     input logic [1:0] src, input logic hs);
    return {12'hABC, 1'b0, m2r, sz, uns, src, 1'b0, 1'b0, hs};
  endfunction

  task automatic drv(input logic [21:0] c, input logic rf, input logic hi, input logic lo,
                     input logic st, input logic [4:0] d, input logic [31:0] alu,
                     input logic [31:0] mem, input logic [31:0] mh, input logic [31:0] ml);
    bus.control_signals = c; bus.rf_enable = rf; bus.hi_enable = hi; bus.lo_enable = lo;
    bus.stall = st; bus.dest_reg = d; bus.alu_result = alu; bus.mem_data = mem;
    bus.mul_hi = mh; bus.mul_lo = ml;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drv(22'h0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (2) step();
    chk("reset_rf_we", {31'b0, rf_we}, 32'h0);
    chk("reset_cnt", retired_count, 32'h0);
    reset = 1'b1;

    // signed byte load, lane 1
    drv(mk(1, 2'b01, 0, 2'b00, 0), 1, 0, 0, 0, 5'd5, 32'h1, 32'h12348578, 0, 0);
    step(); exp_cnt++;
    chk("lb_we", {31'b0, rf_we}, 32'h1);
    chk("lb_waddr", {27'b0, rf_waddr}, 32'd5);
    chk("lb_wdata", rf_wdata, 32'hFFFFFF85);
    chk("lb_fwd_valid", {31'b0, fwd_valid}, 32'h1);
    chk("lb_fwd_data", fwd_data, 32'hFFFFFF85);
    chk("lb_cnt", retired_count, exp_cnt);

    drv(mk(1, 2'b01, 1, 2'b00, 0), 1, 0, 0, 0, 5'd5, 32'h1, 32'h12348578, 0, 0);
    step(); exp_cnt++;
    chk("lbu_wdata", rf_wdata, 32'h00000085);

    drv(mk(1, 2'b01, 0, 2'b00, 0), 1, 0, 0, 0, 5'd5, 32'h3, 32'h92348578, 0, 0);
    step(); exp_cnt++;
    chk("lb_lane3", rf_wdata, 32'hFFFFFF92);

    // halves: offset bit 0 ignored
    drv(mk(1, 2'b10, 0, 2'b00, 0), 1, 0, 0, 0, 5'd7, 32'h3, 32'h80017FFF, 0, 0);
    step(); exp_cnt++;
    chk("lh_hi", rf_wdata, 32'hFFFF8001);
    drv(mk(1, 2'b10, 1, 2'b00, 0), 1, 0, 0, 0, 5'd7, 32'h2, 32'h80017FFF, 0, 0);
    step(); exp_cnt++;
    chk("lhu_hi", rf_wdata, 32'h00008001);
    drv(mk(1, 2'b10, 0, 2'b00, 0), 1, 0, 0, 0, 5'd7, 32'h1, 32'h80017FFF, 0, 0);
    step(); exp_cnt++;
    chk("lh_lo", rf_wdata, 32'h00007FFF);
    drv(mk(1, 2'b11, 0, 2'b00, 0), 1, 0, 0, 0, 5'd7, 32'h2, 32'h80017FFF, 0, 0);
    step(); exp_cnt++;
    chk("lw_sz11", rf_wdata, 32'h80017FFF);

    // MULT then MFHI / MFLO
    drv(mk(0, 2'b00, 0, 2'b00, 0), 0, 1, 1, 0, 5'd0, 32'h0, 32'h0, 32'hA, 32'hB);
    step(); exp_cnt++;
    chk("mult_hi", hi_out, 32'hA);
    chk("mult_lo", lo_out, 32'hB);
    chk("mult_we", {31'b0, rf_we}, 32'h0);
    chk("mult_cnt", retired_count, exp_cnt);
    drv(mk(0, 2'b00, 0, 2'b01, 0), 1, 0, 0, 0, 5'd3, 32'h0, 32'h0, 32'h0, 32'h0);
    step(); exp_cnt++;
    chk("mfhi", rf_wdata, 32'hA);
    drv(mk(0, 2'b00, 0, 2'b10, 0), 1, 0, 0, 0, 5'd4, 32'h0, 32'h0, 32'h0, 32'h0);
    step(); exp_cnt++;
    chk("mflo", rf_wdata, 32'hB);

    // MTHI 1, then MTHI 2 bundled with MFHI: read-before-write
    drv(mk(0, 2'b00, 0, 2'b00, 1), 0, 1, 0, 0, 5'd0, 32'h1, 32'h0, 32'hF, 32'hF);
    step(); exp_cnt++;
    chk("mthi", hi_out, 32'h1);
    chk("mthi_lo_hold", lo_out, 32'hB);
    drv(mk(0, 2'b00, 0, 2'b01, 1), 1, 1, 0, 0, 5'd6, 32'h2, 32'h0, 32'hF, 32'hF);
    step(); exp_cnt++;
    chk("rbw_wdata", rf_wdata, 32'h1);
    chk("rbw_hi", hi_out, 32'h2);
    chk("rbw_cnt", retired_count, exp_cnt);

    // write to $0: no strobe, fwd sticky, still retires
    drv(mk(0, 2'b00, 0, 2'b11, 0), 1, 0, 0, 0, 5'd0, 32'h55, 32'h0, 0, 0);
    step(); exp_cnt++;
    chk("r0_we", {31'b0, rf_we}, 32'h0);
    chk("r0_fwd_reg", {27'b0, fwd_reg}, 32'd6);
    chk("r0_fwd_data", fwd_data, 32'h1);
    chk("r0_cnt", retired_count, exp_cnt);

    // stall: nothing commits, rf address/data hold
    drv(mk(0, 2'b00, 0, 2'b00, 1), 1, 1, 1, 1, 5'd7, 32'h99, 32'h0, 0, 0);
    step();
    chk("stall_we", {31'b0, rf_we}, 32'h0);
    chk("stall_waddr", {27'b0, rf_waddr}, 32'd0);
    chk("stall_wdata", rf_wdata, 32'h55);
    chk("stall_hi", hi_out, 32'h2);
    chk("stall_fwd", {27'b0, fwd_reg}, 32'd6);
    chk("stall_cnt", retired_count, exp_cnt);

    // async reset mid-cycle
    drv(mk(0, 2'b00, 0, 2'b00, 0), 1, 0, 0, 0, 5'd9, 32'h77, 32'h0, 0, 0);
    step(); exp_cnt++;
    chk("pre_rst_we", {31'b0, rf_we}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("arst_we", {31'b0, rf_we}, 32'h0);
    chk("arst_hi", hi_out, 32'h0);
    chk("arst_fwd", {31'b0, fwd_valid}, 32'h0);
    chk("arst_cnt", retired_count, 32'h0);
    reset = 1'b1;
    exp_cnt = 0;
    step(); exp_cnt++;
    chk("post_rst_we", {31'b0, rf_we}, 32'h1);
    chk("post_rst_wdata", rf_wdata, 32'h77);
    chk("post_rst_cnt", retired_count, exp_cnt);

    // drive the 4-bit counter to its max, then one more commit wraps it
    while (exp_cnt[3:0] != 4'hF) begin
      step(); exp_cnt++;
    end
    chk("cnt4_max", {28'b0, retired_count4}, 32'hF);
    step(); exp_cnt++;
    chk("cnt4_wrap", {28'b0, retired_count4}, 32'h0);
    chk("cnt32_nowrap", retired_count, exp_cnt);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
